// File: rtl/decrypt_sequencer.sv
`timescale 1ns/1ps
// decrypt_sequencer
//   Control FSM for the LFSR decryption datapath. It owns the single dat_mem
//   port and the LFSR bank controls. The datapath does the XOR and compare
//   work; this block only sequences it.
//   Phases, in order: seed capture, tap trial, keystream decode, pad-count
//   scan, pad strip.
//
// Ports
//   clk        rising-edge clock
//   init_n     async active-low reset
//   start      begin a sequence; only sampled in IDLE/DONE/FAIL
//   data_out   dat_mem combinational read data for the current raddr
//   match      per-trial LFSR state == data_out[5:0]^6'h1f, this cycle
//   raddr      dat_mem read address
//   waddr      dat_mem write address
//   write_en   dat_mem write strobe
//   wsel       write mux: 0=data_out^ks, 1=data_out, 2=PAD_CHAR
//   lfsr_load  load all trial LFSRs from data_out
//   final_load load the final LFSR with taps[tap_sel] and the seed
//   lfsr_en    advance the trial and final LFSRs one step
//   tap_sel    chosen tap index
//   km         number of leading PAD_CHAR bytes found by the scan
//   busy       high in every state except IDLE, DONE and FAIL
//   done       high in DONE or FAIL
//   err        high in FAIL (no candidate tap survived)
module decrypt_sequencer #(
  parameter int unsigned MSG_LEN  = 64,
  parameter int unsigned CT_BASE  = 64,
  parameter int unsigned PRE_LEN  = 7,
  parameter int unsigned NUM_TAPS = 6,
  parameter logic [7:0]  PAD_CHAR = 8'h5f
) (
  input  logic                clk,
  input  logic                init_n,
  input  logic                start,
  input  logic [7:0]          data_out,
  input  logic [NUM_TAPS-1:0] match,
  output logic [7:0]          raddr,
  output logic [7:0]          waddr,
  output logic                write_en,
  output logic [1:0]          wsel,
  output logic                lfsr_load,
  output logic                final_load,
  output logic                lfsr_en,
  output logic [2:0]          tap_sel,
  output logic [5:0]          km,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [7:0] CT_BASE_B  = 8'(CT_BASE);
  localparam logic [7:0] LAST_TRIAL = 8'(PRE_LEN - 1);
  localparam logic [7:0] LAST_BYTE  = 8'(MSG_LEN - 1);
  localparam logic [5:0] KM_MAX     = 6'(MSG_LEN - 1);
  localparam logic [8:0] MSG_LEN_W  = 9'(MSG_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_SEED, S_TRIAL, S_CHECK, S_LOAD,
    S_DECODE, S_SCAN, S_STRIP, S_DONE, S_FAIL
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          i_q, i_d;
  logic [NUM_TAPS-1:0] alive_q, alive_d;
  logic [2:0]          tap_q, tap_d;
  logic [5:0]          km_q, km_d;
  logic                padrun_q, padrun_d;
  logic [2:0]          low_idx;
  logic [8:0]          strip_src;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      alive_q  <= '1;
      tap_q    <= '0;
      km_q     <= '0;
      padrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      alive_q  <= alive_d;
      tap_q    <= tap_d;
      km_q     <= km_d;
      padrun_q <= padrun_d;
    end
  end

  // Scan from the top down so the lowest surviving index is left last.
  always_comb begin
    low_idx = '0;
    for (int unsigned t = NUM_TAPS; t > 0; t--) begin
      if (alive_q[t-1]) low_idx = 3'(t - 1);
    end
  end

  assign strip_src = {1'b0, i_q} + {3'b000, km_q};

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    alive_d    = alive_q;
    tap_d      = tap_q;
    km_d       = km_q;
    padrun_d   = padrun_q;
    raddr      = '0;
    waddr      = '0;
    write_en   = 1'b0;
    wsel       = 2'd0;
    lfsr_load  = 1'b0;
    final_load = 1'b0;
    lfsr_en    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SEED;
      end
      S_SEED: begin
        busy      = 1'b1;
        raddr     = CT_BASE_B;
        lfsr_load = 1'b1;
        alive_d   = '1;
        i_d       = 8'd1;
        state_d   = S_TRIAL;
      end
      S_TRIAL: begin
        busy    = 1'b1;
        raddr   = CT_BASE_B + i_q;
        lfsr_en = 1'b1;
        alive_d = alive_q & match;
        i_d     = i_q + 8'd1;
        if (i_q == LAST_TRIAL) state_d = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (alive_q == '0) begin
          state_d = S_FAIL;
        end else begin
          tap_d   = low_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy       = 1'b1;
        raddr      = CT_BASE_B;
        final_load = 1'b1;
        i_d        = '0;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        busy     = 1'b1;
        raddr    = CT_BASE_B + i_q;
        waddr    = i_q;
        write_en = 1'b1;
        wsel     = 2'd0;
        lfsr_en  = 1'b1;
        i_d      = i_q + 8'd1;
        if (i_q == LAST_BYTE) begin
          i_d      = '0;
          km_d     = '0;
          padrun_d = 1'b1;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        busy  = 1'b1;
        raddr = i_q;
        // Count only the unbroken run of pads at the front; saturate so an
        // all-pad message still leaves one byte of source in the strip.
        if (padrun_q) begin
          if (data_out == PAD_CHAR) begin
            if (km_q != KM_MAX) km_d = km_q + 6'd1;
          end else begin
            padrun_d = 1'b0;
          end
        end
        i_d = i_q + 8'd1;
        if (i_q == LAST_BYTE) begin
          i_d     = '0;
          state_d = S_STRIP;
        end
      end
      S_STRIP: begin
        busy     = 1'b1;
        waddr    = i_q;
        write_en = 1'b1;
        if (strip_src < MSG_LEN_W) begin
          raddr = strip_src[7:0];
          wsel  = 2'd1;
        end else begin
          raddr = '0;
          wsel  = 2'd2;
        end
        i_d = i_q + 8'd1;
        if (i_q == LAST_BYTE) begin
          i_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_SEED;
      end
      S_FAIL: begin
        done = 1'b1;
        err  = 1'b1;
        if (start) state_d = S_SEED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tap_sel = tap_q;
  assign km      = km_q;

endmodule

// File: tb/tb_decrypt_sequencer.sv
`timescale 1ns/1ps
module tb_decrypt_sequencer;

  localparam int          MSG_LEN = 64;
  localparam int          CT_BASE = 64;
  localparam logic [7:0]  PAD     = 8'h5f;
  localparam int          RUN_LAT = 202;  // cycle of done, counting the start cycle as 1
  localparam int          FAIL_LAT = 9;

  logic       clk = 1'b0;
  logic       init_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_out;
  logic [5:0] match;
  logic [7:0] raddr, waddr;
  logic       write_en;
  logic [1:0] wsel;
  logic       lfsr_load, final_load, lfsr_en;
  logic [2:0] tap_sel;
  logic [5:0] km;
  logic       busy, done, err;

  always #5 clk = ~clk;

  decrypt_sequencer #(
    .MSG_LEN (64),
    .CT_BASE (64),
    .PRE_LEN (7),
    .NUM_TAPS(6),
    .PAD_CHAR(8'h5f)
  ) dut (
    .clk       (clk),
    .init_n    (init_n),
    .start     (start),
    .data_out  (data_out),
    .match     (match),
    .raddr     (raddr),
    .waddr     (waddr),
    .write_en  (write_en),
    .wsel      (wsel),
    .lfsr_load (lfsr_load),
    .final_load(final_load),
    .lfsr_en   (lfsr_en),
    .tap_sel   (tap_sel),
    .km        (km),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // ---------------- datapath / memory model ----------------
  logic [7:0] ct_mem  [0:255];
  logic [7:0] dat_mem [0:255];
  logic [5:0] match_seq [0:7];
  logic [2:0] tcnt    = '0;
  logic [5:0] fin_q   = '0;
  logic [5:0] fin_tap = '0;
  logic [7:0] wdata;

  function automatic logic [5:0] tap_of(input int unsigned t);
    case (t)
      0: return 6'h21;
      1: return 6'h2D;
      2: return 6'h30;
      3: return 6'h33;
      4: return 6'h36;
      default: return 6'h39;
    endcase
  endfunction

  function automatic logic [5:0] step(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  assign data_out = (raddr >= 8'(CT_BASE)) ? ct_mem[raddr - 8'(CT_BASE)] : dat_mem[raddr];
  assign match    = match_seq[tcnt];

  always_comb begin
    case (wsel)
      2'd0:    wdata = data_out ^ {2'b00, fin_q};
      2'd1:    wdata = data_out;
      default: wdata = PAD;
    endcase
  end

  always @(posedge clk) begin
    if (write_en) dat_mem[waddr] <= wdata;
    if (lfsr_load) tcnt <= 3'd1;
    else if (lfsr_en && tcnt != 3'd7) tcnt <= tcnt + 3'd1;
    if (final_load) begin
      fin_q   <= data_out[5:0] ^ 6'h1f;
      fin_tap <= tap_of(32'(tap_sel));
    end else if (lfsr_en) begin
      fin_q <= step(fin_q, fin_tap);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t        sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] pt [0:63];
  int         km_exp;

  task automatic set_seq(input logic [5:0] a, b, c, d, e, f);
    match_seq[0] = '0; match_seq[7] = '0;
    match_seq[1] = a; match_seq[2] = b; match_seq[3] = c;
    match_seq[4] = d; match_seq[5] = e; match_seq[6] = f;
  endtask

  // Encrypt pt with the given tap/seed into ct_mem and queue the expected writes.
  task automatic encrypt_and_expect(input int unsigned tap, input logic [5:0] seed);
    logic [5:0] s;
    wr_t w;
    s = seed;
    for (int unsigned k = 0; k < MSG_LEN; k++) begin
      ct_mem[k] = pt[k] ^ {2'b00, s};
      s = step(s, tap_of(tap));
    end
    km_exp = 0;
    while (km_exp < MSG_LEN - 1 && pt[km_exp] == PAD) km_exp++;
    for (int unsigned k = 0; k < MSG_LEN; k++) begin
      w.addr = 8'(k); w.data = pt[k];
      sb.push_back(w);
    end
    for (int k = 0; k < MSG_LEN; k++) begin
      w.addr = 8'(k);
      w.data = (k + km_exp < MSG_LEN) ? pt[k + km_exp] : PAD;
      sb.push_back(w);
    end
  endtask

  function automatic int first_mem_diff();
    logic [7:0] e;
    for (int a = 0; a < MSG_LEN; a++) begin
      e = (a + km_exp < MSG_LEN) ? pt[a + km_exp] : PAD;
      if (dat_mem[a] !== e) return a;
    end
    return -1;
  endfunction

  function automatic logic [7:0] mem_exp(input int a);
    return (a + km_exp < MSG_LEN) ? pt[a + km_exp] : PAD;
  endfunction

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
  endtask

  // Steps cycles (sampled at negedge), checking every write against the queue.
  task automatic run_until_done(input int budget, input bit hold, output int done_cyc);
    wr_t e;
    done_cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (write_en) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", waddr, wdata);
        end else begin
          e = sb.pop_front();
          if (waddr !== e.addr || wdata !== e.data) begin
            n_fail++;
            $display("FAIL write_stream: got addr=%0d data=%h, required addr=%0d data=%h",
                     waddr, wdata, e.addr, e.data);
          end
        end
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic msg_tap2();
    for (int k = 0; k < MSG_LEN; k++) pt[k] = (k < 5) ? PAD : 8'h41 + 8'((k * 7) % 26);
    set_seq(6'h3f, 6'h3d, 6'h3e, 6'h2c, 6'h0f, 6'h37);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    init_n = 1'b0;
    start  = 1'b1;
    #1;
    n_checks++;
    if ({raddr, waddr, write_en, wsel, lfsr_load, final_load, lfsr_en, tap_sel, km, busy, done, err} !== 34'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got raddr=%h waddr=%h we=%b busy=%b done=%b, required all 0",
               raddr, waddr, write_en, busy, done);
    end
    start = 1'b0;
    @(negedge clk);
    init_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic check_good_run(input string tag, input int dc, input logic [2:0] tap_exp);
    int bad;
    n_checks++;
    if (dc !== RUN_LAT) begin
      n_fail++; $display("FAIL %s_latency: got %0d, required %0d", tag, dc, RUN_LAT);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL %s_err: got %b, required 0", tag, err);
    end
    n_checks++;
    if (tap_sel !== tap_exp) begin
      n_fail++; $display("FAIL %s_tap_sel: got %0d, required %0d", tag, tap_sel, tap_exp);
    end
    n_checks++;
    if (km !== 6'(km_exp)) begin
      n_fail++; $display("FAIL %s_km: got %0d, required %0d", tag, km, km_exp);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL %s_writes_missing: got %0d pending, required 0", tag, sb.size());
    end
    bad = first_mem_diff();
    n_checks++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL %s_mem: addr %0d got %h, required %h", tag, bad, dat_mem[bad], mem_exp(bad));
    end
  endtask

  task automatic test_decode_tap2();
    int dc;
    msg_tap2();
    encrypt_and_expect(2, 6'h15);
    kick();
    run_until_done(300, 1'b0, dc);
    check_good_run("tap2", dc, 3'd2);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL tap2_done_held: got done=%b busy=%b, required 1 0", done, busy);
    end
  endtask

  task automatic test_no_match();
    int dc;
    for (int unsigned v = 0; v < 2; v++) begin
      if (v == 0) set_seq('0, '0, '0, '0, '0, '0);
      else        set_seq(6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h00);
      sb.delete();
      kick();
      run_until_done(50, 1'b0, dc);
      n_checks++;
      if (dc !== FAIL_LAT) begin
        n_fail++; $display("FAIL nomatch%0d_latency: got %0d, required %0d", v, dc, FAIL_LAT);
      end
      n_checks++;
      if (err !== 1'b1 || done !== 1'b1) begin
        n_fail++; $display("FAIL nomatch%0d_flags: got err=%b done=%b, required 1 1", v, err, done);
      end
    end
  endtask

  task automatic test_lowest_tap();
    int dc;
    pt[0] = 8'h1f;  // low bits look like a pad but the byte is not one: km=0
    for (int k = 1; k < MSG_LEN; k++) pt[k] = 8'h61 + 8'((k * 3) % 26);
    set_seq(6'h3f, 6'h3b, 6'h1a, 6'h13, 6'h32, 6'h12);
    encrypt_and_expect(1, 6'h2a);
    kick();
    run_until_done(300, 1'b0, dc);
    check_good_run("lowtap", dc, 3'd1);
  endtask

  task automatic test_all_pad();
    int dc;
    for (int k = 0; k < MSG_LEN; k++) pt[k] = PAD;
    set_seq(6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20);
    encrypt_and_expect(5, 6'h01);
    kick();
    run_until_done(300, 1'b0, dc);
    check_good_run("allpad", dc, 3'd5);
  endtask

  task automatic test_reset_mid();
    int dc;
    msg_tap2();
    encrypt_and_expect(2, 6'h15);
    kick();
    run_until_done(40, 1'b0, dc);  // stops in DECODE with i=30 on the bus
    n_checks++;
    if (dc !== -1 || write_en !== 1'b1 || waddr !== 8'd30) begin
      n_fail++; $display("FAIL mid_position: got done_cyc=%0d we=%b waddr=%0d, required -1 1 30", dc, write_en, waddr);
    end
    #1 init_n = 1'b0;
    #1;
    n_checks++;
    if ({raddr, waddr, write_en, wsel, lfsr_load, final_load, lfsr_en, tap_sel, km, busy, done, err} !== 34'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got raddr=%h waddr=%h we=%b busy=%b tap=%0d, required all 0",
               raddr, waddr, write_en, busy, tap_sel);
    end
    sb.delete();
    @(negedge clk);
    n_checks++;
    if (dat_mem[30] !== PAD || dat_mem[29] !== pt[29]) begin
      n_fail++; $display("FAIL mid_partial_write: got mem29=%h mem30=%h, required %h %h", dat_mem[29], dat_mem[30], pt[29], PAD);
    end
    init_n = 1'b1;
    encrypt_and_expect(2, 6'h15);
    kick();
    run_until_done(300, 1'b0, dc);
    check_good_run("after_reset", dc, 3'd2);
  endtask

  task automatic test_back_to_back();
    int dc;
    msg_tap2();
    encrypt_and_expect(2, 6'h15);
    kick();
    run_until_done(300, 1'b1, dc);
    check_good_run("held1", dc, 3'd2);
    encrypt_and_expect(2, 6'h15);
    run_until_done(300, 1'b0, dc);
    check_good_run("held2", dc, 3'd2);
  endtask

  initial begin
    test_reset();
    test_decode_tap2();
    test_no_match();
    test_lowest_tap();
    test_all_pad();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
